// File: rtl/aes_mix_pkg.sv
// Shared types, GF(2^8) helpers and matrix constants for the MixColumns engine.
package aes_mix_pkg;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned COL_W    = 32;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned STATE_W  = 128;

  typedef logic [STATE_W-1:0] state_t;
  typedef logic [COL_W-1:0]   col_t;
  typedef logic [BYTE_W-1:0]  byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mix_state_e;

  // First matrix row; row r is this row rotated right by r.
  typedef logic [0:NUM_COLS-1][BYTE_W-1:0] row_coef_t;
  localparam row_coef_t FWD_ROW0 = {8'h02, 8'h03, 8'h01, 8'h01};
  localparam row_coef_t INV_ROW0 = {8'h0e, 8'h0b, 8'h0d, 8'h09};

  // Clock edges spent in BUSY for one state.
  function automatic int unsigned num_steps(input int unsigned cols_per_cycle);
    return NUM_COLS / cols_per_cycle;
  endfunction

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by one of the fixed MixColumns coefficients using xtime chains.
  function automatic byte_t gf_mul_const(input byte_t b, input byte_t c);
    byte_t x2, x4, x8, res;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (c)
      8'h01:   res = b;
      8'h02:   res = x2;
      8'h03:   res = x2 ^ b;
      8'h09:   res = x8 ^ b;
      8'h0b:   res = x8 ^ x2 ^ b;
      8'h0d:   res = x8 ^ x4 ^ b;
      8'h0e:   res = x8 ^ x4 ^ x2;
      default: res = 8'h00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mix_columns_engine_if.sv
// Input/output handshake bundle for the MixColumns engine.
interface mix_columns_engine_if;
  import aes_mix_pkg::*;

  logic   in_valid;
  logic   in_ready;
  state_t in_state;
  logic   in_inv;
  logic   out_valid;
  logic   out_ready;
  state_t out_state;

  modport slave (
    input  in_valid, in_state, in_inv, out_ready,
    output in_ready, out_valid, out_state
  );

  modport master (
    output in_valid, in_state, in_inv, out_ready,
    input  in_ready, out_valid, out_state
  );

endinterface

// File: rtl/mix_column_word.sv
// Combinational MixColumns / InvMixColumns of a single 32-bit column.
module mix_column_word
  import aes_mix_pkg::*;
(
  input  logic [31:0] col_in,
  input  logic        inv,
  output logic [31:0] col_out
);

  byte_t     a [NUM_COLS];
  row_coef_t row0;

  always_comb begin
    for (int unsigned k = 0; k < NUM_COLS; k++) begin
      a[k] = col_in[31-8*k -: 8];
    end
  end

  assign row0 = inv ? INV_ROW0 : FWD_ROW0;

  // out_row[r] = XOR_k M0[(k-r) mod 4] * in_row[k]
  always_comb begin
    col_out = '0;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        col_out[31-8*r -: 8] = col_out[31-8*r -: 8] ^ gf_mul_const(a[k], row0[2'(k - r)]);
      end
    end
  end

endmodule

// File: rtl/mix_columns_engine.sv
// Sequential MixColumns engine: accepts a 128-bit state, transforms
// COLS_PER_CYCLE columns per clock in place, then holds the result.
module mix_columns_engine
  import aes_mix_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  mix_columns_engine_if.slave   bus
);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
      $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  localparam int unsigned N        = num_steps(COLS_PER_CYCLE);
  localparam logic [1:0]  LAST_IDX = 2'((N - 1) * COLS_PER_CYCLE);
  localparam logic [1:0]  IDX_STEP = 2'(COLS_PER_CYCLE);

  mix_state_e state_q, state_d;
  logic [1:0] col_idx_q, col_idx_d;
  state_t     work_q, work_d;
  logic       mode_q, mode_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;

  col_t cols [NUM_COLS];
  col_t src  [COLS_PER_CYCLE];
  col_t res  [COLS_PER_CYCLE];

  // State register and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = BUSY;
      BUSY:    if (col_idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the next state so they are flops, not decode of inputs.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    case (state_d)
      IDLE:    in_ready_d  = 1'b1;
      DONE:    out_valid_d = 1'b1;
      default: ;
    endcase
  end

  // Column view of the working register; column 0 occupies the MSBs.
  genvar c, j;
  generate
    for (c = 0; c < NUM_COLS; c++) begin : g_cols
      assign cols[c] = work_q[127-32*c -: 32];
    end
    for (j = 0; j < COLS_PER_CYCLE; j++) begin : g_lane
      assign src[j] = cols[2'(col_idx_q + 2'(j))];
      mix_column_word u_word (
        .col_in  (src[j]),
        .inv     (mode_q),
        .col_out (res[j])
      );
    end
  endgenerate

  // Working register, column counter and latched direction.
  always_comb begin
    work_d    = work_q;
    col_idx_d = col_idx_q;
    mode_d    = mode_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d    = bus.in_state;
          mode_d    = bus.in_inv;
          col_idx_d = 2'd0;
        end
      end
      BUSY: begin
        for (int unsigned l = 0; l < COLS_PER_CYCLE; l++) begin
          for (int unsigned k = 0; k < NUM_COLS; k++) begin
            if (2'(col_idx_q + 2'(l)) == 2'(k)) work_d[127-32*k -: 32] = res[l];
          end
        end
        col_idx_d = col_idx_q + IDX_STEP;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work_q    <= '0;
      col_idx_q <= 2'd0;
      mode_q    <= 1'b0;
    end else begin
      work_q    <= work_d;
      col_idx_q <= col_idx_d;
      mode_q    <= mode_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_state = work_q;

endmodule
